// File: rtl/randsack_wb_arbiter.sv
// rtl/randsack_wb_arbiter.sv - two-master round-robin Wishbone arbiter with per-transaction watchdog
module randsack_wb_arbiter #(
    parameter int              AW       = 32,
    parameter int              DW       = 32,
    parameter int              TIMEOUT  = 255,
    parameter logic [DW-1:0]   ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clock,
    input  logic              resetb,

    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [DW/8-1:0]   m0_sel,
    input  logic [AW-1:0]     m0_adr,
    input  logic [DW-1:0]     m0_dat_w,
    output logic [DW-1:0]     m0_dat_r,
    output logic              m0_ack,
    output logic              m0_err,

    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [DW/8-1:0]   m1_sel,
    input  logic [AW-1:0]     m1_adr,
    input  logic [DW-1:0]     m1_dat_w,
    output logic [DW-1:0]     m1_dat_r,
    output logic              m1_ack,
    output logic              m1_err,

    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    output logic [DW/8-1:0]   s_sel,
    output logic [AW-1:0]     s_adr,
    output logic [DW-1:0]     s_dat_w,
    input  logic [DW-1:0]     s_dat_r,
    input  logic              s_ack,

    output logic              busy,
    output logic              owner,
    output logic [7:0]        timeout_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ERR   = 2'd2
    } state_e;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic       g_q, g_d;
    logic       last_q, last_d;
    logic [7:0] wd_q, wd_d;
    logic [7:0] tcnt_q, tcnt_d;

    logic            req0, req1;
    logic            mg_cyc, mg_stb, mg_we;
    logic [DW/8-1:0] mg_sel;
    logic [AW-1:0]   mg_adr;
    logic [DW-1:0]   mg_dat_w;

    assign req0 = m0_cyc & m0_stb;
    assign req1 = m1_cyc & m1_stb;

    // Request fields of the granted master; not registered, masters hold them stable.
    assign mg_cyc   = g_q ? m1_cyc   : m0_cyc;
    assign mg_stb   = g_q ? m1_stb   : m0_stb;
    assign mg_we    = g_q ? m1_we    : m0_we;
    assign mg_sel   = g_q ? m1_sel   : m0_sel;
    assign mg_adr   = g_q ? m1_adr   : m0_adr;
    assign mg_dat_w = g_q ? m1_dat_w : m0_dat_w;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
            g_q     <= 1'b0;
            last_q  <= 1'b1;
            wd_q    <= 8'd0;
            tcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        last_d   = last_q;
        wd_d     = wd_q;
        tcnt_d   = tcnt_q;

        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_sel    = '0;
        s_adr    = '0;
        s_dat_w  = '0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_dat_r = '0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_dat_r = '0;

        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    // On a tie the master that was not served last wins.
                    g_d     = (req0 & req1) ? ~last_q : req1;
                    wd_d    = 8'd0;
                    state_d = ST_GRANT;
                end
            end

            ST_GRANT: begin
                s_cyc   = mg_cyc;
                s_stb   = mg_stb;
                s_we    = mg_we;
                s_sel   = mg_sel;
                s_adr   = mg_adr;
                s_dat_w = mg_dat_w;
                if (g_q) begin
                    m1_ack   = s_ack;
                    m1_dat_r = s_dat_r;
                end else begin
                    m0_ack   = s_ack;
                    m0_dat_r = s_dat_r;
                end

                // Ack takes precedence over a watchdog expiry in the same cycle.
                if (s_ack || !mg_cyc) begin
                    last_d  = g_q;
                    state_d = ST_IDLE;
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end

            ST_ERR: begin
                if (g_q) begin
                    m1_err   = 1'b1;
                    m1_dat_r = ERR_DATA;
                end else begin
                    m0_err   = 1'b1;
                    m0_dat_r = ERR_DATA;
                end
                tcnt_d  = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
                last_d  = g_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign owner       = g_q;
    assign timeout_cnt = tcnt_q;

endmodule
